uart_arbiter: RTL

UART_ARBITER -- requirements
Module: uart_arbiter

---
 rtl/uart_arbiter_pkg.sv | 15 +
 rtl/uart_arbiter_timer.sv | 32 +++
 rtl/uart_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_arbiter_pkg.sv
// uart_arbiter_pkg: shared state enum and grant encodings
// for the two-master uart write arbiter.
package uart_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/uart_arbiter_timer.sv
// uart_arbiter_timer: saturating idle-cycle counter that
// flags expiry on the cycle the count reaches TIMEOUT-1.
module uart_arbiter_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WARN = CW'(TIMEOUT - 2);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expire as the count steps onto TIMEOUT-1 so release is next cycle.
  assign o_expire = i_enable && (r_cnt >= WARN);

endmodule

// File: rtl/uart_arbiter.sv
// uart_arbiter: round-robin two-master write arbiter for a uart.
// Optional grant locking with timeout: UART_ARBITER_LOCK_EN.
module uart_arbiter
  import uart_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_write,
  input  logic [DW-1:0] m0_writedata,
  input  logic          m0_lock,
  output logic          m0_waitrequest,
  input  logic          m1_write,
  input  logic [DW-1:0] m1_writedata,
  input  logic          m1_lock,
  output logic          m1_waitrequest,
  output logic          avalon_write,
  output logic [DW-1:0] avalon_writedata,
  input  logic          avalon_waitrequest,
  output logic [1:0]    grant
);

  state_t     r_state;
  logic       r_ptr;
  logic [1:0] r_grant;
  logic       r_stalled;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_wr;
  logic [DW-1:0] w_data;
  logic          w_done;
  logic          w_lock;
  logic          w_expire;
  logic          w_pick0;
  logic          w_pick1;

  assign w_gnt0 = (r_state == GNT0);
  assign w_gnt1 = (r_state == GNT1);

  assign w_wr   = (w_gnt0 & m0_write) | (w_gnt1 & m1_write);
  assign w_data = w_gnt0 ? m0_writedata :
                  w_gnt1 ? m1_writedata : '0;
  assign w_done = w_wr & ~avalon_waitrequest;

  // r_ptr=1 means m1 wins the next tie.
  assign w_pick0 = m0_write & (~m1_write | ~r_ptr);
  assign w_pick1 = m1_write & ~w_pick0;

`ifdef UART_ARBITER_LOCK_EN
  logic w_clr;
  logic w_hold;

  assign w_lock = (w_gnt0 & m0_lock) | (w_gnt1 & m1_lock);
  assign w_clr  = ~(w_gnt0 | w_gnt1) | w_wr;
  assign w_hold = (w_gnt0 | w_gnt1) & ~w_wr & w_lock;

  uart_arbiter_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clr),
    .i_enable (w_hold),
    .o_expire (w_expire)
  );
`else
  logic w_unused_lock;

  assign w_unused_lock = m0_lock | m1_lock;
  assign w_lock        = 1'b0;
  assign w_expire      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_grant   <= GRANT_NONE;
      r_stalled <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_stalled <= 1'b0;
          if (w_pick0) begin
            r_state <= GNT0;
            r_grant <= GRANT_M0;
          end else if (w_pick1) begin
            r_state <= GNT1;
            r_grant <= GRANT_M1;
          end
        end
        GNT0, GNT1: begin
          r_stalled <= w_wr & avalon_waitrequest;
          if (w_done) begin
            r_ptr <= w_gnt0;
            if (!w_lock) begin
              r_state <= IDLE;
              r_grant <= GRANT_NONE;
            end
          end else if (!w_wr && (r_stalled || !w_lock || w_expire)) begin
            // Dropped mid-stall, unlocked idle, or hold timeout.
            r_state <= IDLE;
            r_grant <= GRANT_NONE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_grant   <= GRANT_NONE;
          r_stalled <= 1'b0;
        end
      endcase
    end
  end

  assign avalon_write     = w_wr;
  assign avalon_writedata = w_data;
  assign m0_waitrequest   = w_gnt0 ? avalon_waitrequest : 1'b1;
  assign m1_waitrequest   = w_gnt1 ? avalon_waitrequest : 1'b1;
  assign grant            = r_grant;

endmodule
